// File: rtl/mmio_io_responder_pkg.sv
// Shared address map and status bit positions for the MMIO responder.
// Used by the responder, the data-memory read mux and program images.
// Constants only; no timing or flow-control content.
package mmio_io_responder_pkg;

    localparam logic [7:0] IN_ADDR   = 8'hF9;
    localparam logic [7:0] STAT_ADDR = 8'hFA;
    localparam logic [7:0] CNT_ADDR  = 8'hFB;
    localparam logic [7:0] RES_BASE  = 8'hFD;

    localparam int STAT_FULL = 0;
    localparam int STAT_OVR  = 1;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_PEND = 1'b1
    } out_state_t;

    function automatic logic addr_hit(input logic [7:0] a);
        return (a == IN_ADDR) || (a == STAT_ADDR) || (a == CNT_ADDR) ||
               (a == RES_BASE) || (a == RES_BASE + 8'd1) || (a == RES_BASE + 8'd2);
    endfunction

endpackage

// File: rtl/mmio_io_responder.sv
// MMIO responder: latches external samples for the CPU, hands CPU-written results to the display side.
// Latency: register updates visible one cycle after the triggering edge; RDATA/HIT are combinational.
// Backpressure: SAMPLE_READY low while a sample is unread; result overwrite while pending sets sticky overrun.
module mmio_io_responder
    import mmio_io_responder_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] ADDR,
    input  logic       WE,
    input  logic       RE,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       HIT,
    input  logic [7:0] SAMPLE_IN,
    input  logic       SAMPLE_VALID,
    output logic       SAMPLE_READY,
    output logic [7:0] RES_A,
    output logic [7:0] RES_B,
    output logic [7:0] RES_C,
    output logic       RES_VALID,
    input  logic       RES_ACK
);

    in_state_t  in_state,  in_state_nxt;
    out_state_t out_state, out_state_nxt;
    logic [7:0] in_reg,     in_reg_nxt;
    logic [7:0] sample_cnt, sample_cnt_nxt;
    logic [7:0] res_a,      res_a_nxt;
    logic [7:0] res_b,      res_b_nxt;
    logic [7:0] res_c,      res_c_nxt;
    logic       overrun,    overrun_nxt;

    logic in_full;
    logic rd_in;
    logic wr_a;
    logic wr_b;
    logic wr_c;
    logic wr_stat;
    logic ovr_set;

    assign in_full = (in_state == IN_FULL);
    assign rd_in   = RE && (ADDR == IN_ADDR);
    assign wr_a    = WE && (ADDR == RES_BASE);
    assign wr_b    = WE && (ADDR == RES_BASE + 8'd1);
    assign wr_c    = WE && (ADDR == RES_BASE + 8'd2);
    assign wr_stat = WE && (ADDR == STAT_ADDR);

    assign SAMPLE_READY = !in_full && !RESET;
    assign RES_A        = res_a;
    assign RES_B        = res_b;
    assign RES_C        = res_c;
    assign RES_VALID    = (out_state == OUT_PEND);
    assign HIT          = addr_hit(ADDR);

    // Input path: accept one sample when empty, release it when the CPU reads the data register.
    always_comb begin
        in_state_nxt   = in_state;
        in_reg_nxt     = in_reg;
        sample_cnt_nxt = sample_cnt;
        case (in_state)
            IN_EMPTY: begin
                if (SAMPLE_VALID && SAMPLE_READY) begin
                    in_state_nxt   = IN_FULL;
                    in_reg_nxt     = SAMPLE_IN;
                    sample_cnt_nxt = sample_cnt + 8'd1;
                end
            end
            IN_FULL: begin
                if (rd_in) begin
                    in_state_nxt = IN_EMPTY;
                end
            end
            default: in_state_nxt = IN_EMPTY;
        endcase
    end

    // Output path: commit byte raises RES_VALID; overwriting an unacked result flags overrun.
    always_comb begin
        out_state_nxt = out_state;
        res_a_nxt     = wr_a ? WDATA : res_a;
        res_b_nxt     = wr_b ? WDATA : res_b;
        res_c_nxt     = wr_c ? WDATA : res_c;
        ovr_set       = 1'b0;
        case (out_state)
            OUT_IDLE: begin
                if (wr_c) begin
                    out_state_nxt = OUT_PEND;
                end
            end
            OUT_PEND: begin
                if (wr_c) begin
                    // A commit in the ack cycle replaces the consumed set cleanly.
                    ovr_set = !RES_ACK;
                end else if (RES_ACK) begin
                    out_state_nxt = OUT_IDLE;
                end
            end
            default: out_state_nxt = OUT_IDLE;
        endcase
        overrun_nxt = overrun;
        if (wr_stat && WDATA[STAT_OVR]) begin
            overrun_nxt = 1'b0;
        end
        if (ovr_set) begin
            overrun_nxt = 1'b1;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_state   <= IN_EMPTY;
            out_state  <= OUT_IDLE;
            in_reg     <= 8'h00;
            sample_cnt <= 8'h00;
            res_a      <= 8'h00;
            res_b      <= 8'h00;
            res_c      <= 8'h00;
            overrun    <= 1'b0;
        end else begin
            in_state   <= in_state_nxt;
            out_state  <= out_state_nxt;
            in_reg     <= in_reg_nxt;
            sample_cnt <= sample_cnt_nxt;
            res_a      <= res_a_nxt;
            res_b      <= res_b_nxt;
            res_c      <= res_c_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Read mux for the CPU load path.
    always_comb begin
        RDATA = 8'h00;
        if (ADDR == IN_ADDR) begin
            RDATA = in_reg;
        end else if (ADDR == STAT_ADDR) begin
            RDATA = {6'b0, overrun, in_full};
        end else if (ADDR == CNT_ADDR) begin
            RDATA = sample_cnt;
        end else if (ADDR == RES_BASE) begin
            RDATA = res_a;
        end else if (ADDR == RES_BASE + 8'd1) begin
            RDATA = res_b;
        end else if (ADDR == RES_BASE + 8'd2) begin
            RDATA = res_c;
        end
    end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder with a behavioural reference model.
// Inputs change 1 time unit after posedge; outputs are compared at every negedge.
// Literal checks pin key values of the model along the directed sequence.
module tb_mmio_io_responder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] ADDR;
    logic       WE;
    logic       RE;
    logic [7:0] WDATA;
    logic [7:0] RDATA;
    logic       HIT;
    logic [7:0] SAMPLE_IN;
    logic       SAMPLE_VALID;
    logic       SAMPLE_READY;
    logic [7:0] RES_A;
    logic [7:0] RES_B;
    logic [7:0] RES_C;
    logic       RES_VALID;
    logic       RES_ACK;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // reference model state
    logic [7:0] m_in, m_cnt;
    logic       m_full, m_ovr, m_vld;
    logic [7:0] m_res [3];

    mmio_io_responder dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WE(WE), .RE(RE), .WDATA(WDATA),
        .RDATA(RDATA), .HIT(HIT), .SAMPLE_IN(SAMPLE_IN), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_READY(SAMPLE_READY), .RES_A(RES_A), .RES_B(RES_B), .RES_C(RES_C),
        .RES_VALID(RES_VALID), .RES_ACK(RES_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'hF9:   return m_in;
            8'hFA:   return {6'b0, m_ovr, m_full};
            8'hFB:   return m_cnt;
            8'hFD:   return m_res[0];
            8'hFE:   return m_res[1];
            8'hFF:   return m_res[2];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic m_hit(input logic [7:0] a);
        return a inside {8'hF9, 8'hFA, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    // Model: apply the bus/handshake rules to the inputs present at each edge.
    always @(posedge CLK) begin
        if (RESET) begin
            m_in = 0; m_cnt = 0; m_full = 0; m_ovr = 0; m_vld = 0;
            m_res[0] = 0; m_res[1] = 0; m_res[2] = 0;
        end else begin
            bit set_ovr;
            set_ovr = 0;
            if (m_full) begin
                if (RE && ADDR == 8'hF9) m_full = 0;
            end else if (SAMPLE_VALID) begin
                m_in = SAMPLE_IN; m_cnt = m_cnt + 8'd1; m_full = 1;
            end
            if (WE && ADDR == 8'hFD) m_res[0] = WDATA;
            if (WE && ADDR == 8'hFE) m_res[1] = WDATA;
            if (WE && ADDR == 8'hFF) begin
                if (m_vld && !RES_ACK) set_ovr = 1;
                m_res[2] = WDATA;
                m_vld = 1;
            end else if (RES_ACK) begin
                m_vld = 0;
            end
            if (WE && ADDR == 8'hFA && WDATA[1]) m_ovr = 0;
            if (set_ovr) m_ovr = 1;
        end
    end

    // Compare every output against the model each cycle once reset has been seen.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_rdata", RDATA, m_read(ADDR));
            chk("cyc_hit", HIT, m_hit(ADDR));
            chk("cyc_ready", SAMPLE_READY, !m_full && !RESET);
            chk("cyc_res_a", RES_A, m_res[0]);
            chk("cyc_res_b", RES_B, m_res[1]);
            chk("cyc_res_c", RES_C, m_res[2]);
            chk("cyc_res_valid", RES_VALID, m_vld);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
        ADDR = a;
        #1;
        chk(name, RDATA, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ADDR = a; WDATA = d; WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd_in();
        ADDR = 8'hF9; RE = 1'b1;
        tick();
        RE = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        SAMPLE_IN = d; SAMPLE_VALID = 1'b1;
        tick();
        SAMPLE_VALID = 1'b0;
    endtask

    logic [7:0] hit_map;

    initial begin
        RESET = 1; ADDR = 0; WE = 0; RE = 0; WDATA = 0;
        SAMPLE_IN = 0; SAMPLE_VALID = 0; RES_ACK = 0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("ready_in_reset", SAMPLE_READY, 1'b0);
        RESET = 0;
        #1;
        chk("ready_after_reset", SAMPLE_READY, 1'b1);
        peek("rst_in", 8'hF9, 8'h00);
        peek("rst_stat", 8'hFA, 8'h00);
        peek("rst_cnt", 8'hFB, 8'h00);
        chk("rst_res_valid", RES_VALID, 1'b0);

        // address decode around the top of the map
        hit_map = 8'b1110_1110;
        for (int a = 8'hF8; a <= 8'hFF; a++) begin
            ADDR = 8'(a);
            #1;
            chk("hit_decode", HIT, hit_map[a - 8'hF8]);
        end
        peek("rd_fc_zero", 8'hFC, 8'h00);
        tick();

        // first sample
        push(8'd72);
        chk("ready_full", SAMPLE_READY, 1'b0);
        peek("in_72", 8'hF9, 8'd72);
        peek("stat_full", 8'hFA, 8'h01);
        peek("cnt_1", 8'hFB, 8'd1);

        // read releases, held VALID refills next cycle
        SAMPLE_IN = 8'd80; SAMPLE_VALID = 1'b1;
        rd_in();
        peek("stat_after_read", 8'hFA, 8'h00);
        peek("in_stale", 8'hF9, 8'd72);
        tick();
        SAMPLE_VALID = 1'b0;
        peek("in_80", 8'hF9, 8'd80);
        peek("cnt_2", 8'hFB, 8'd2);
        peek("stat_refull", 8'hFA, 8'h01);

        // writes to read-only registers ignored
        wr(8'hFB, 8'h55);
        peek("cnt_ro", 8'hFB, 8'd2);
        wr(8'hF9, 8'h33);
        peek("in_ro", 8'hF9, 8'd80);
        rd_in();

        // result handoff
        wr(8'hFD, 8'd9);
        wr(8'hFE, 8'd8);
        chk("no_pend_before_commit", RES_VALID, 1'b0);
        wr(8'hFF, 8'hFF);
        chk("res_a_9", RES_A, 8'd9);
        chk("res_b_8", RES_B, 8'd8);
        chk("res_c_ff", RES_C, 8'hFF);
        chk("res_valid_set", RES_VALID, 1'b1);
        RES_ACK = 1'b1;
        tick();
        RES_ACK = 1'b0;
        chk("res_valid_acked", RES_VALID, 1'b0);
        RES_ACK = 1'b1;
        tick();
        RES_ACK = 1'b0;
        chk("ack_idle_ignored", RES_VALID, 1'b0);

        // overrun and clear
        wr(8'hFF, 8'd1);
        wr(8'hFF, 8'd2);
        peek("stat_ovr", 8'hFA, 8'h02);
        wr(8'hFA, 8'h01);
        peek("stat_ovr_keep", 8'hFA, 8'h02);
        wr(8'hFA, 8'h02);
        peek("stat_ovr_clr", 8'hFA, 8'h00);
        ADDR = 8'hFF; WDATA = 8'd3; WE = 1'b1; RES_ACK = 1'b1;
        tick();
        WE = 1'b0; RES_ACK = 1'b0;
        chk("commit_ack_valid", RES_VALID, 1'b1);
        chk("commit_ack_data", RES_C, 8'd3);
        peek("commit_ack_no_ovr", 8'hFA, 8'h00);
        RES_ACK = 1'b1;
        tick();
        RES_ACK = 1'b0;

        // counter wrap: 254 more accepted samples from count 2
        for (int i = 0; i < 254; i++) begin
            push(8'(i));
            rd_in();
        end
        peek("cnt_wrap", 8'hFB, 8'h00);
        peek("in_last", 8'hF9, 8'd253);
        rd_in();
        peek("empty_read_cnt", 8'hFB, 8'h00);
        peek("empty_read_stat", 8'hFA, 8'h00);

        // reset while FULL and PEND
        push(8'd99);
        wr(8'hFD, 8'd7);
        wr(8'hFF, 8'd5);
        chk("pre_rst_valid", RES_VALID, 1'b1);
        RESET = 1'b1;
        #1;
        chk("ready_rst_high", SAMPLE_READY, 1'b0);
        tick();
        chk("rst_mid_res_a", RES_A, 8'h00);
        chk("rst_mid_res_c", RES_C, 8'h00);
        chk("rst_mid_valid", RES_VALID, 1'b0);
        peek("rst_mid_in", 8'hF9, 8'h00);
        peek("rst_mid_cnt", 8'hFB, 8'h00);
        RESET = 1'b0;
        #1;
        chk("ready_after_mid_rst", SAMPLE_READY, 1'b1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
